// File: rtl/snake_pkg.sv
// ============================================================================
// Module   : snake_pkg
// Brief    : Shared direction encoding, FSM state type and helpers for the
//            snake move arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Opposite directions differ only in the MSB, which is the DIR_DOWN bit.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return a == (b ^ DIR_DOWN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/move_fifo.sv
// ============================================================================
// Module   : move_fifo
// Brief    : Two-entry direction FIFO with last-accepted register and
//            request accept/reject logic for one player.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_fifo
    import snake_pkg::*;
#(
    parameter dir_t INIT_DIR = DIR_UP
) (
    input  logic clock,
    input  logic reset,
    input  dir_t dir_in,
    input  logic dir_valid,
    input  logic pop,
    output dir_t head,
    output logic empty,
    output logic reject
);

    logic [1:0] r_count;
    dir_t       r_mem0;
    dir_t       r_mem1;
    dir_t       r_last;

    logic w_pop;
    logic w_full;
    logic w_legal;
    logic w_accept;

    assign w_pop    = pop && (r_count != 2'd0);
    assign w_full   = (r_count == 2'd2);
    assign w_legal  = (dir_in != r_last) && !is_reverse(dir_in, r_last);
    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign w_accept = dir_valid && w_legal && (!w_full || w_pop);

    assign reject = dir_valid && !w_accept;
    assign head   = r_mem0;
    assign empty  = (r_count == 2'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= 2'd0;
            r_mem0  <= DIR_UP;
            r_mem1  <= DIR_UP;
            r_last  <= INIT_DIR;
        end else begin
            if (w_accept) begin
                r_last <= dir_in;
            end
            case ({w_pop, w_accept})
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= dir_in;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= dir_in;
                    end
                end
                2'b10: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd0) begin
                        r_mem0 <= dir_in;
                    end else begin
                        r_mem1 <= dir_in;
                    end
                    r_count <= r_count + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/snake_move_arbiter.sv
// ============================================================================
// Module   : snake_move_arbiter
// Brief    : Buffers two players' direction requests and commits one move per
//            player each game tick, holding a step strobe until acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_move_arbiter
    import snake_pkg::*;
#(
    parameter int   TICK_CYCLES = 50000,
    parameter dir_t INIT_DIR1   = DIR_RIGHT,
    parameter dir_t INIT_DIR2   = DIR_LEFT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  dir_in1,
    input  logic        dir_valid1,
    input  logic [1:0]  dir_in2,
    input  logic        dir_valid2,
    input  logic        step_ack,
    output logic [31:0] move1,
    output logic [31:0] move2,
    output logic        step,
    output logic        overrun,
    output logic [7:0]  drop_count
);

    localparam int                CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic             r_step;
    logic             r_overrun;
    dir_t             r_move1;
    dir_t             r_move2;
    logic [7:0]       r_drop;

    logic       w_expiry;
    logic       w_pop;
    dir_t       w_head1;
    dir_t       w_head2;
    logic       w_empty1;
    logic       w_empty2;
    logic       w_reject1;
    logic       w_reject2;
    logic [8:0] w_drop_sum;

    assign w_expiry = (r_cnt == CNT_LAST);
    assign w_pop    = (r_state == COMMIT);

    move_fifo #(.INIT_DIR(INIT_DIR1)) u_fifo1 (
        .clock     (clock),
        .reset     (reset),
        .dir_in    (dir_in1),
        .dir_valid (dir_valid1),
        .pop       (w_pop),
        .head      (w_head1),
        .empty     (w_empty1),
        .reject    (w_reject1)
    );

    move_fifo #(.INIT_DIR(INIT_DIR2)) u_fifo2 (
        .clock     (clock),
        .reset     (reset),
        .dir_in    (dir_in2),
        .dir_valid (dir_valid2),
        .pop       (w_pop),
        .head      (w_head2),
        .empty     (w_empty2),
        .reject    (w_reject2)
    );

    // Free-running tick counter; it keeps counting while a step is pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_expiry) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_step    <= 1'b0;
            r_overrun <= 1'b0;
            r_move1   <= INIT_DIR1;
            r_move2   <= INIT_DIR2;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_expiry) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (!w_empty1) begin
                        r_move1 <= w_head1;
                    end
                    if (!w_empty2) begin
                        r_move2 <= w_head2;
                    end
                    r_step  <= 1'b1;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A tick expiring here is dropped, only flagged.
                    if (w_expiry) begin
                        r_overrun <= 1'b1;
                    end
                    if (step_ack) begin
                        r_step  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_step  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_drop_sum = {1'b0, r_drop} + {8'd0, w_reject1} + {8'd0, w_reject2};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_drop <= 8'd0;
        end else begin
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign move1      = {30'd0, r_move1};
    assign move2      = {30'd0, r_move2};
    assign step       = r_step;
    assign overrun    = r_overrun;
    assign drop_count = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_snake_move_arbiter.sv
// ============================================================================
// Module   : tb_snake_move_arbiter
// Brief    : Directed and randomized bench for snake_move_arbiter against a
//            queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_move_arbiter;

    localparam int T = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  dir_in1 = 2'd0;
    logic        dir_valid1 = 1'b0;
    logic [1:0]  dir_in2 = 2'd0;
    logic        dir_valid2 = 1'b0;
    logic        step_ack = 1'b0;
    logic [31:0] move1;
    logic [31:0] move2;
    logic        step;
    logic        overrun;
    logic [7:0]  drop_count;

    always #5 clock = ~clock;

    snake_move_arbiter #(
        .TICK_CYCLES (T),
        .INIT_DIR1   (2'd1),
        .INIT_DIR2   (2'd3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dir_in1    (dir_in1),
        .dir_valid1 (dir_valid1),
        .dir_in2    (dir_in2),
        .dir_valid2 (dir_valid2),
        .step_ack   (step_ack),
        .move1      (move1),
        .move2      (move2),
        .step       (step),
        .overrun    (overrun),
        .drop_count (drop_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] q1[$];
    logic [1:0] q2[$];
    logic [1:0] last1, last2, mm1, mm2;
    bit         ms, mo, mc;
    int         md;
    int         cyc;

    function automatic bit legal(input logic [1:0] d, input logic [1:0] l);
        return (d != l) && (d != 2'((l + 2) % 4));
    endfunction

    always @(posedge clock or negedge reset) begin : model
        bit ex, pop, a1, a2, nxt_step, nxt_commit;
        int rej;
        if (!reset) begin
            q1.delete();
            q2.delete();
            last1 = 2'd1; last2 = 2'd3;
            mm1 = 2'd1;   mm2 = 2'd3;
            ms = 0; mo = 0; mc = 0; md = 0; cyc = 0;
        end else begin
            ex  = (cyc % T) == (T - 1);
            pop = mc;
            rej = 0;
            a1 = dir_valid1 && legal(dir_in1, last1) && (q1.size() < 2 || (pop && q1.size() > 0));
            a2 = dir_valid2 && legal(dir_in2, last2) && (q2.size() < 2 || (pop && q2.size() > 0));
            if (pop && q1.size() > 0) mm1 = q1.pop_front();
            if (pop && q2.size() > 0) mm2 = q2.pop_front();
            if (a1) begin q1.push_back(dir_in1); last1 = dir_in1; end
            if (a2) begin q2.push_back(dir_in2); last2 = dir_in2; end
            if (dir_valid1 && !a1) rej++;
            if (dir_valid2 && !a2) rej++;
            md = (md + rej > 255) ? 255 : md + rej;
            if (ms && ex) mo = 1;
            nxt_step   = mc ? 1'b1 : ((ms && step_ack) ? 1'b0 : ms);
            nxt_commit = !mc && !ms && ex;
            ms  = nxt_step;
            mc  = nxt_commit;
            cyc = cyc + 1;
        end
    end

    always @(negedge clock) begin
        chk("move1", move1, {30'd0, mm1});
        chk("move2", move2, {30'd0, mm2});
        chk("step", {31'd0, step}, {31'd0, ms});
        chk("overrun", {31'd0, overrun}, {31'd0, mo});
        chk("drop_count", {24'd0, drop_count}, 32'(md));
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_step(input string name);
        int n = 0;
        while (!step && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!step) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: step still 0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic wait_commit(input string name);
        int n = 0;
        while (!mc && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!mc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: commit cycle not reached after %0d cycles", name, n);
        end
    endtask

    task automatic ack();
        step_ack = 1'b1;
        @(negedge clock);
        step_ack = 1'b0;
    endtask

    task automatic strobe(input int p, input logic [1:0] d);
        if (p == 1) begin dir_in1 = d; dir_valid1 = 1'b1; end
        else        begin dir_in2 = d; dir_valid2 = 1'b1; end
        @(negedge clock);
        dir_valid1 = 1'b0;
        dir_valid2 = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_move1", move1, 32'd1);
        chk("rst_move2", move2, 32'd3);
        chk("rst_step", {31'd0, step}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        reset = 1'b1;

        // reversal reject then legal turn
        strobe(1, 2'd3);
        strobe(1, 2'd0);
        chk("rev_drop", {24'd0, drop_count}, 32'd1);
        wait_step("rev_step");
        chk("rev_step_cycle", 32'(cyc), 32'd9);
        chk("rev_move1", move1, 32'd0);
        chk("rev_move2", move2, 32'd3);
        ack();
        chk("rev_step_fall", {31'd0, step}, 32'd0);

        // queue full on player 2
        strobe(2, 2'd0);
        strobe(2, 2'd1);
        strobe(2, 2'd2);
        chk("full_drop", {24'd0, drop_count}, 32'd2);
        wait_step("full_step1");
        chk("full_move2_a", move2, 32'd0);
        ack();
        wait_step("full_step2");
        chk("full_move2_b", move2, 32'd1);
        ack();

        // push during COMMIT into a full FIFO
        strobe(1, 2'd1);
        strobe(1, 2'd2);
        wait_commit("cm_commit");
        strobe(1, 2'd3);
        wait_step("cm_step1");
        chk("cm_drop", {24'd0, drop_count}, 32'd2);
        chk("cm_move1_a", move1, 32'd1);
        ack();
        wait_step("cm_step2");
        chk("cm_move1_b", move1, 32'd2);
        ack();
        wait_step("cm_step3");
        chk("cm_move1_c", move1, 32'd3);

        // missing ack across an expiry
        strobe(2, 2'd2);
        repeat (11) @(negedge clock);
        chk("ovr_overrun", {31'd0, overrun}, 32'd1);
        chk("ovr_step", {31'd0, step}, 32'd1);
        chk("ovr_move2", move2, 32'd1);
        ack();
        chk("ovr_single_step", {31'd0, step}, 32'd0);
        wait_step("ovr_step2");
        chk("ovr_move2_b", move2, 32'd2);
        chk("ovr_move1_b", move1, 32'd3);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        // saturation then reset while waiting for ack
        step_ack = 1'b1;
        dir_in1 = 2'd3; dir_in2 = 2'd2;
        dir_valid1 = 1'b1; dir_valid2 = 1'b1;
        repeat (150) @(negedge clock);
        dir_valid1 = 1'b0; dir_valid2 = 1'b0;
        step_ack = 1'b0;
        chk("sat_drop", {24'd0, drop_count}, 32'd255);
        wait_step("sat_step");
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_step", {31'd0, step}, 32'd0);
        chk("mid_rst_move1", move1, 32'd1);
        chk("mid_rst_move2", move2, 32'd3);
        chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        chk("mid_rst_drop", {24'd0, drop_count}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            dir_valid1 = ($urandom_range(0, 2) == 0);
            dir_in1    = 2'($urandom_range(0, 3));
            dir_valid2 = ($urandom_range(0, 2) == 0);
            dir_in2    = 2'($urandom_range(0, 3));
            step_ack   = ($urandom_range(0, 3) == 0);
            if (i == 1700) begin
                #3 reset = 1'b0;
                @(negedge clock);
                reset = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        dir_valid1 = 1'b0;
        dir_valid2 = 1'b0;
        step_ack   = 1'b0;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
